uart_tx: RTL

UART transmitter, the transmit-side counterpart of the team's UART receiver. It serialises a PAYLOAD_BITS-wide word onto uart_txd as a frame: start bit (0), data LSB first, then STOP_BITS stop bits (1). It also generates a BREAK condition on request. It sits between a host-side valid/busy handshake and the TX pin.

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises a PAYLOAD_BITS word as
// start bit (0), data LSB first, STOP_BITS stop bits (1). It can also
// send a BREAK: the line is held low for a whole frame, then stop bits follow.
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high reset
//   uart_tx_en     send request for uart_tx_data (sampled only when idle)
//   uart_tx_data   word to send, captured on acceptance
//   uart_tx_break  break request (sampled only when idle, wins over uart_tx_en)
//   uart_tx_busy   high while a frame or break is in progress
//   uart_txd       registered serial line, idles high
module uart_tx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_break,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int unsigned BIT_P          = 1000000000 / BIT_RATE;
    localparam int unsigned CLK_P          = 1000000000 / CLK_HZ;
    localparam int unsigned CYCLES_PER_BIT = BIT_P / CLK_P;
    localparam int unsigned BREAK_BITS     = 1 + PAYLOAD_BITS + STOP_BITS;

    localparam logic [15:0] CYC_LAST   = 16'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [4:0]  BREAK_LAST = 5'(BREAK_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                  state;
    logic [15:0]             cyc_cnt;
    logic [3:0]              bit_cnt;
    logic [4:0]              brk_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [PAYLOAD_BITS-1:0] shreg_nxt;
    logic                    cyc_done;

    assign cyc_done  = (cyc_cnt == CYC_LAST);
    assign shreg_nxt = shreg >> 1;

    // Single-process FSM; txd/busy are set on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            brk_cnt      <= '0;
            shreg        <= '0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cyc_cnt      <= '0;
                    bit_cnt      <= '0;
                    brk_cnt      <= '0;
                    uart_txd     <= 1'b1;
                    uart_tx_busy <= 1'b0;
                    // Break has priority; data is not captured for a break.
                    if (uart_tx_break) begin
                        state        <= S_BREAK;
                        uart_txd     <= 1'b0;
                        uart_tx_busy <= 1'b1;
                    end else if (uart_tx_en) begin
                        shreg        <= uart_tx_data;
                        state        <= S_START;
                        uart_txd     <= 1'b0;
                        uart_tx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    bit_cnt <= '0;
                    brk_cnt <= '0;
                    if (cyc_done) begin
                        cyc_cnt  <= '0;
                        state    <= S_DATA;
                        uart_txd <= shreg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    brk_cnt <= '0;
                    if (cyc_done) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            state    <= S_STOP;
                            bit_cnt  <= '0;
                            uart_txd <= 1'b1;
                        end else begin
                            shreg    <= shreg_nxt;
                            uart_txd <= shreg_nxt[0];
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end

                // bit_cnt counts stop bits here
                S_STOP: begin
                    brk_cnt  <= '0;
                    uart_txd <= 1'b1;
                    if (cyc_done) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            state        <= S_IDLE;
                            bit_cnt      <= '0;
                            uart_tx_busy <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end

                // Line low for a full frame's worth of bit times
                S_BREAK: begin
                    bit_cnt <= '0;
                    if (cyc_done) begin
                        cyc_cnt <= '0;
                        if (brk_cnt == BREAK_LAST) begin
                            state    <= S_STOP;
                            brk_cnt  <= '0;
                            uart_txd <= 1'b1;
                        end else begin
                            brk_cnt <= brk_cnt + 5'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    cyc_cnt      <= '0;
                    bit_cnt      <= '0;
                    brk_cnt      <= '0;
                    uart_txd     <= 1'b1;
                    uart_tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
